// File: rtl/us_ranging_ctrl.sv
// Ultrasonic ranging sequencer for an HC-SR04-style sensor.
// Generates the trigger pulse, times the echo in microsecond ticks, converts
// the echo width to distance in 0.01 mm units and repeats every PERIOD_US.
module us_ranging_ctrl #(
  parameter int CYC_PER_US   = 50,
  parameter int TRIG_US      = 10,
  parameter int RISE_WAIT_US = 2000,
  parameter int MAX_ECHO_US  = 30000,
  parameter int PERIOD_US    = 60000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        en,
  input  logic        echo,
  output logic        trig,
  output logic [18:0] data_o,
  output logic        data_vld,
  output logic        timeout_err,
  output logic        busy
);

  localparam int                TICK_W    = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CYC_PER_US - 1);
  localparam logic [15:0]       TRIG_LAST = 16'(TRIG_US - 1);
  localparam logic [15:0]       RISE_LAST = 16'(RISE_WAIT_US - 1);
  localparam logic [15:0]       ECHO_MAX  = 16'(MAX_ECHO_US);
  localparam logic [15:0]       PER_LAST  = 16'(PERIOD_US - 1);
  localparam logic [18:0]       DIST_FAR  = 19'h7FFFF;

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_CALC, S_DONE, S_HOLD
  } state_t;

  state_t              state, state_nxt;
  logic [TICK_W-1:0]   tick_cnt;
  logic                tick;
  logic                echo_meta_p0, echo_sync_p1, echo_prev_p2;
  logic                echo_rise, echo_fall;
  logic                trig_start, state_chg;
  logic [15:0]         tmr_us;
  logic [15:0]         echo_us;
  logic [15:0]         period_us;

  // Echo width (us) to distance: us * 1097 / 64, clamped to the 19-bit range.
  function automatic logic [18:0] sat_dist(input logic [15:0] us);
    logic [26:0] prod;
    prod = {11'd0, us} * 27'd1097;
    if (prod[26:25] != 2'b00) return DIST_FAR;
    return prod[24:6];
  endfunction

  assign tick       = (tick_cnt == TICK_LAST);
  assign echo_rise  = echo_sync_p1 & ~echo_prev_p2;
  assign echo_fall  = ~echo_sync_p1 & echo_prev_p2;
  assign trig_start = (state_nxt == S_TRIG) && (state != S_TRIG);
  assign state_chg  = (state_nxt != state);

  // Two-flop synchronizer for the asynchronous echo pin, plus a delayed copy for edge detection.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      echo_meta_p0 <= 1'b0;
      echo_sync_p1 <= 1'b0;
      echo_prev_p2 <= 1'b0;
    end else begin
      echo_meta_p0 <= echo;
      echo_sync_p1 <= echo_meta_p0;
      echo_prev_p2 <= echo_sync_p1;
    end
  end

  // Free-running microsecond prescaler, realigned on trigger start so the pulse width is exact.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)               tick_cnt <= '0;
    else if (trig_start || tick) tick_cnt <= '0;
    else                      tick_cnt <= tick_cnt + 1'b1;
  end

  // Per-state microsecond timer (trigger width, rise wait) and start-to-start period counter.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      tmr_us    <= '0;
      period_us <= '0;
    end else begin
      if (state_chg)  tmr_us <= '0;
      else if (tick)  tmr_us <= tmr_us + 16'd1;
      if (trig_start)                        period_us <= '0;
      else if (tick && period_us != PER_LAST) period_us <= period_us + 16'd1;
    end
  end

  // Echo width counter; the rise cycle itself counts so the window covers the whole synced pulse.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)
      echo_us <= '0;
    else if (state == S_WAIT_RISE && echo_rise)
      echo_us <= tick ? 16'd1 : 16'd0;
    else if (state == S_MEASURE && echo_sync_p1 && tick && echo_us != ECHO_MAX)
      echo_us <= echo_us + 16'd1;
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a detected edge takes priority over a coincident timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (en) state_nxt = S_TRIG;
      S_TRIG:      if (tick && tmr_us == TRIG_LAST) state_nxt = S_WAIT_RISE;
      S_WAIT_RISE: begin
        if (echo_rise)                         state_nxt = S_MEASURE;
        else if (tick && tmr_us == RISE_LAST)  state_nxt = S_DONE;
      end
      S_MEASURE: begin
        if (echo_fall)                state_nxt = S_CALC;
        else if (echo_us == ECHO_MAX) state_nxt = S_DONE;
      end
      S_CALC:      state_nxt = S_DONE;
      S_DONE:      state_nxt = S_HOLD;
      S_HOLD: begin
        if (!en)                              state_nxt = S_IDLE;
        else if (tick && period_us == PER_LAST) state_nxt = S_TRIG;
      end
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs; the result lands on entry to DONE so data_o and data_vld align.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      trig        <= 1'b0;
      busy        <= 1'b0;
      data_vld    <= 1'b0;
      data_o      <= DIST_FAR;
      timeout_err <= 1'b0;
    end else begin
      trig     <= (state_nxt == S_TRIG);
      busy     <= (state_nxt != S_IDLE);
      data_vld <= (state_nxt == S_DONE);
      if (state_nxt == S_DONE) begin
        if (state == S_CALC) begin
          data_o      <= sat_dist(echo_us);
          timeout_err <= 1'b0;
        end else begin
          data_o      <= DIST_FAR;
          timeout_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_us_ranging_ctrl.sv
// Testbench for us_ranging_ctrl, run with shortened timing parameters.
module tb_us_ranging_ctrl;

  localparam int CYC  = 2;
  localparam int TRIG = 10;
  localparam int RISE = 60;
  localparam int MAXE = 1300;
  localparam int PER  = 1500;
  localparam logic [18:0] FAR = 19'h7FFFF;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        en = 1'b0;
  logic        echo = 1'b0;
  logic        trig;
  logic [18:0] data_o;
  logic        data_vld;
  logic        timeout_err;
  logic        busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  us_ranging_ctrl #(
    .CYC_PER_US(CYC), .TRIG_US(TRIG), .RISE_WAIT_US(RISE),
    .MAX_ECHO_US(MAXE), .PERIOD_US(PER)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .en(en), .echo(echo), .trig(trig),
    .data_o(data_o), .data_vld(data_vld), .timeout_err(timeout_err), .busy(busy)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Reference distance: 0.01 mm units at 343 m/s round trip, clamped to 19 bits.
  function automatic int ref_dist(input int w_us);
    longint p;
    p = (longint'(w_us) * 1097) >>> 6;
    if (p > 524287) p = 524287;
    return int'(p);
  endfunction

  task automatic wait_trig(input logic lvl, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (trig === lvl) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_vld(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (data_vld === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  // One full measurement: echo of w_us after d_us (w_us=0 means no echo at all).
  task automatic measure(input int d_us, input int w_us, output logic ok,
                         output logic [18:0] d, output logic e, output logic vld_after);
    logic a, b, c;
    wait_trig(1'b1, PER*CYC + 50, a);
    wait_trig(1'b0, TRIG*CYC + 10, b);
    if (w_us > 0) begin
      repeat (d_us*CYC) @(negedge Clk);
      echo = 1'b1;
      repeat (w_us*CYC) @(negedge Clk);
      echo = 1'b0;
    end
    wait_vld((RISE + MAXE)*CYC + 100, c);
    d = data_o;
    e = timeout_err;
    @(negedge Clk);
    vld_after = data_vld;
    ok = a & b & c;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; en = 1'b0; echo = 1'b0;
    repeat (3) @(negedge Clk);
    total++; if (trig !== 1'b0) begin bad++; $display("FAIL reset_trig got=%0b exp=0", trig); end
    total++; if (data_o !== FAR) begin bad++; $display("FAIL reset_data got=%0d exp=%0d", data_o, FAR); end
    total++; if (data_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%0b exp=0", data_vld); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", timeout_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_timeout_period();
    logic a, b, c, v2, d;
    int t_rise, t_fall, t_vld;
    en = 1'b1;
    wait_trig(1'b1, 10, a); t_rise = cyc;
    wait_trig(1'b0, TRIG*CYC + 10, b); t_fall = cyc;
    total++; if (!(a && b) || (t_fall - t_rise) != TRIG*CYC) begin
      bad++; $display("FAIL trig_width got=%0d exp=%0d", t_fall - t_rise, TRIG*CYC); end
    wait_vld((RISE + 10)*CYC, c); t_vld = cyc;
    total++; if (!c || (t_vld - t_fall) != RISE*CYC) begin
      bad++; $display("FAIL rise_timeout_time got=%0d exp=%0d", t_vld - t_fall, RISE*CYC); end
    total++; if (data_o !== FAR || timeout_err !== 1'b1) begin
      bad++; $display("FAIL rise_timeout_result got=%0d/%0b exp=%0d/1", data_o, timeout_err, FAR); end
    @(negedge Clk);
    total++; if (data_vld !== 1'b0) begin bad++; $display("FAIL vld_single got=%0b exp=0", data_vld); end
    wait_trig(1'b1, PER*CYC + 50, v2);
    d = v2;
    total++; if (!d || (cyc - t_rise) != PER*CYC) begin
      bad++; $display("FAIL period got=%0d exp=%0d", cyc - t_rise, PER*CYC); end
  endtask

  task automatic test_echo_20cm();
    logic ok, e, va; logic [18:0] d;
    measure(3, 1166, ok, d, e, va);
    total++; if (!ok || d !== 19'd19985 || e !== 1'b0) begin
      bad++; $display("FAIL echo_1166 got=%0d/%0b exp=19985/0", d, e); end
    total++; if (va !== 1'b0) begin bad++; $display("FAIL echo_1166_vld_once got=%0b exp=0", va); end
  endtask

  task automatic test_err_recover();
    logic ok, e, va; logic [18:0] d;
    measure(5, 583, ok, d, e, va);
    total++; if (!ok || d !== 19'd9992 || e !== 1'b0) begin
      bad++; $display("FAIL echo_583 got=%0d/%0b exp=9992/0", d, e); end
    measure(0, 0, ok, d, e, va);
    total++; if (!ok || d !== FAR || e !== 1'b1) begin
      bad++; $display("FAIL no_echo got=%0d/%0b exp=%0d/1", d, e, FAR); end
    measure(7, 583, ok, d, e, va);
    total++; if (!ok || d !== 19'd9992 || e !== 1'b0) begin
      bad++; $display("FAIL err_clear got=%0d/%0b exp=9992/0", d, e); end
  endtask

  task automatic test_stuck_high();
    logic a, b, c, ok, e, va; logic [18:0] d;
    int t0, dt;
    wait_trig(1'b1, PER*CYC + 50, a);
    wait_trig(1'b0, TRIG*CYC + 10, b);
    repeat (3*CYC) @(negedge Clk);
    echo = 1'b1; t0 = cyc;
    wait_vld(MAXE*CYC + 50, c); dt = cyc - t0;
    total++; if (!(a && b && c) || data_o !== FAR || timeout_err !== 1'b1) begin
      bad++; $display("FAIL echo_max_result got=%0d/%0b exp=%0d/1", data_o, timeout_err, FAR); end
    total++; if (dt < MAXE*CYC || dt > MAXE*CYC + 8) begin
      bad++; $display("FAIL echo_max_time got=%0d exp=%0d..%0d", dt, MAXE*CYC, MAXE*CYC + 8); end
    wait_trig(1'b1, PER*CYC + 50, a);
    wait_trig(1'b0, TRIG*CYC + 10, b);
    t0 = cyc;
    wait_vld(RISE*CYC + 50, c); dt = cyc - t0;
    total++; if (!(a && b && c) || dt != RISE*CYC || timeout_err !== 1'b1) begin
      bad++; $display("FAIL stuck_high got=%0d/%0b exp=%0d/1", dt, timeout_err, RISE*CYC); end
    echo = 1'b0;
    measure(4, 100, ok, d, e, va);
    total++; if (!ok || d !== 19'(ref_dist(100)) || e !== 1'b0) begin
      bad++; $display("FAIL after_stuck got=%0d/%0b exp=%0d/0", d, e, ref_dist(100)); end
  endtask

  task automatic test_random();
    logic ok, e, va; logic [18:0] d;
    int w, dl, exp_d;
    logic exp_e;
    for (int i = 0; i < 4; i++) begin
      w  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 1250));
      dl = int'($urandom_range(1, 20));
      exp_d = (w == 0) ? int'(FAR) : ref_dist(w);
      exp_e = (w == 0);
      measure(dl, w, ok, d, e, va);
      total++; if (!ok || d !== 19'(exp_d) || e !== exp_e) begin
        bad++; $display("FAIL random w=%0d got=%0d/%0b exp=%0d/%0b", w, d, e, exp_d, exp_e); end
    end
  endtask

  task automatic test_en_drop_hold();
    logic a, b, c;
    en = 1'b1;
    wait_trig(1'b1, PER*CYC + 50, a);
    wait_trig(1'b0, TRIG*CYC + 10, b);
    wait_vld((RISE + 10)*CYC, c);
    repeat (10) @(negedge Clk);
    en = 1'b0;
    @(negedge Clk);
    total++; if (!(a && b && c) || busy !== 1'b0) begin
      bad++; $display("FAIL en_drop_hold busy got=%0b exp=0", busy); end
  endtask

  task automatic test_en_drop_measure();
    logic a, b, c, idle;
    int trigs;
    en = 1'b1;
    wait_trig(1'b1, 20, a);
    wait_trig(1'b0, TRIG*CYC + 10, b);
    repeat (3*CYC) @(negedge Clk);
    echo = 1'b1;
    repeat (100*CYC) @(negedge Clk);
    en = 1'b0;
    repeat (200*CYC) @(negedge Clk);
    echo = 1'b0;
    wait_vld(100, c);
    total++; if (!(a && b && c) || data_o !== 19'(ref_dist(300)) || timeout_err !== 1'b0) begin
      bad++; $display("FAIL en_drop_meas got=%0d/%0b exp=%0d/0", data_o, timeout_err, ref_dist(300)); end
    idle = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (busy === 1'b0) begin idle = 1'b1; break; end
    end
    total++; if (!idle) begin bad++; $display("FAIL en_drop_idle busy got=%0b exp=0", busy); end
    trigs = 0;
    for (int i = 0; i < PER*CYC + 100; i++) begin
      @(negedge Clk);
      if (trig !== 1'b0) trigs++;
    end
    total++; if (trigs != 0) begin bad++; $display("FAIL no_retrigger got=%0d exp=0", trigs); end
  endtask

  task automatic test_reset_mid_trig();
    logic a, ok, e, va; logic [18:0] d;
    en = 1'b1;
    wait_trig(1'b1, 20, a);
    repeat (2) @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    total++; if (!a || trig !== 1'b0) begin bad++; $display("FAIL async_reset_trig got=%0b exp=0", trig); end
    total++; if (data_o !== FAR || busy !== 1'b0 || data_vld !== 1'b0 || timeout_err !== 1'b0) begin
      bad++; $display("FAIL async_reset_outs got=%0d/%0b/%0b/%0b exp=%0d/0/0/0",
                      data_o, busy, data_vld, timeout_err, FAR); end
    @(negedge Clk);
    Rst_n = 1'b1;
    measure(3, 1166, ok, d, e, va);
    total++; if (!ok || d !== 19'd19985 || e !== 1'b0) begin
      bad++; $display("FAIL restart got=%0d/%0b exp=19985/0", d, e); end
  endtask

  initial begin
    test_reset();
    test_timeout_period();
    test_echo_20cm();
    test_err_recover();
    test_stuck_high();
    test_random();
    test_en_drop_hold();
    test_en_drop_measure();
    test_reset_mid_trig();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/us_ranging_ctrl.md
Name: us_ranging_ctrl

Overview:
Measurement sequencer for the HC-SR04-style ultrasonic sensor. It issues the trigger pulse, times the echo, converts echo width to distance and schedules periodic measurements. The distance output data_o (19 bits, units of 0.01 mm, so data_o/1000 = cm) feeds the existing beep/LED alarm logic. Runs on the 50 MHz system clock.

Parameters:
CYC_PER_US, 50, system clock cycles per microsecond tick
TRIG_US, 10, trigger high time in µs
RISE_WAIT_US, 2000, maximum wait from trigger fall to echo rise before timeout
MAX_ECHO_US, 30000, maximum echo high time before timeout
PERIOD_US, 60000, start-to-start measurement period in µs (must exceed TRIG_US+RISE_WAIT_US+MAX_ECHO_US)

Ports:
Clk  input  1  system clock, 50 MHz
Rst_n  input  1  asynchronous active-low reset
en  input  1  continuous-measurement enable, synchronous level
echo  input  1  sensor echo pin, asynchronous to Clk
trig  output  1  sensor trigger pin
data_o  output  19  last distance, 0.01 mm units
data_vld  output  1  one-cycle pulse when data_o is updated
timeout_err  output  1  last measurement timed out; cleared on next good result
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE, trig=0, data_o=19'h7FFFF (far, alarm silent), data_vld=0, timeout_err=0, busy=0. All counters and synchronizer flops = 0. Reset mid-measurement drops trig on reset assertion, not at a clock edge.
- echo passes through a 2-flop synchronizer. Edges are detected on the synchronized signal, adding 2 cycles of latency, which is accepted.
- µs tick: a free-running counter 0..CYC_PER_US-1 pulses tick at wrap. It restarts from 0 on entry to TRIG, so trig width is exact.
- FSM:
  IDLE: if en=1, go to TRIG next cycle and clear the period counter.
  TRIG: trig=1 for TRIG_US ticks (10 µs = 500 cycles exactly), then trig=0 and go to WAIT_RISE.
  WAIT_RISE: on synced echo rise, clear echo_us and go to MEASURE. If RISE_WAIT_US ticks elapse first, flag a timeout and go to DONE.
  MEASURE: increment echo_us (16 bit) per tick while echo is high. On synced echo fall, go to CALC. If echo_us reaches MAX_ECHO_US, flag a timeout and go to DONE.
  CALC: one cycle. dist = (echo_us * 1097) >> 6, a 27-bit product; 1097/64 ≈ 17.14 units per µs at 343 m/s round trip. If the result exceeds 19 bits, saturate to 19'h7FFFF. Go to DONE.
  DONE: one cycle. On success: data_o <= dist, timeout_err <= 0. On timeout: data_o <= 19'h7FFFF, timeout_err <= 1. In both cases data_vld=1 this cycle only. Then go to HOLD.
  HOLD: wait until the period counter, which counts ticks from TRIG entry, reaches PERIOD_US, then go to TRIG if en=1 else IDLE. If en falls during HOLD, go to IDLE the next cycle.
- en deassert during TRIG, WAIT_RISE, MEASURE or CALC does not abort. The measurement completes, DONE reports it, then the FSM goes to IDLE.
- An echo already high on entry to WAIT_RISE is not a rise. The FSM waits for a genuine 0→1 edge; a stuck-high echo produces a timeout.
- Echo rise and RISE_WAIT_US expiry in the same cycle: the rise wins. Echo fall and MAX_ECHO_US in the same cycle: the fall wins and the result goes through CALC.
- data_o and timeout_err hold their values between data_vld pulses and while in IDLE.

Test Plan:
- Reset, en=1, echo held low → trig high for exactly 500 cycles; after 2000 µs, data_vld pulses once with data_o=524287 and timeout_err=1; next trig starts 60000 µs after the first.
- Echo high for 1166 µs after trig fall → data_o=19985 (≈20 cm), timeout_err=0, data_vld pulses once.
- Echo high for 583 µs → data_o=9992; then a timeout run → timeout_err=1; then a 583 µs echo again → timeout_err cleared to 0.
- Echo held high for 40000 µs → timeout at echo_us=30000, data_o=524287, timeout_err=1; the next cycle waits for a fresh rise.
- en dropped mid-MEASURE → the result is still reported; FSM reaches IDLE with busy=0 and no further trig. en dropped in HOLD → IDLE within 1 cycle.
- Rst_n asserted while trig=1 → trig=0 immediately; all outputs return to reset values; restart after release behaves normally.
